// File: rtl/iob_spi_slave_fl.sv
// SPI mode-0 slave that looks like a small serial flash (READ, PROGRAM,
// JEDEC ID, STATUS) and bridges it onto a byte-wide valid/ready memory port.
module iob_spi_slave_fl #(
  parameter logic [23:0] ID_VALUE    = 24'hEF4018,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SCLK,
  input  logic        SS,
  input  logic        MOSI,
  output logic        MISO,
  output logic        mem_valid,
  output logic [23:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_wstrb,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready,
  input  logic [7:0]  status,
  output logic        underrun,
  output logic        frame_done
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, TX, RX, IGNORE} state_e;
  typedef enum logic [1:0] {OP_READ, OP_PROG, OP_ID, OP_STATUS} op_e;

  localparam logic [4:0] SETTLE = 5'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q;
  logic        sclk_prev_q, ss_prev_q, armed_q;
  logic [4:0]  settle_q;

  state_e      state_q;
  op_e         op_q;
  logic [7:0]  shift_q, tx_q, rbuf_q, wdata_q;
  logic [4:0]  bit_cnt_q;
  logic [2:0]  tx_cnt_q;
  logic [1:0]  id_idx_q;
  logic [23:0] addr_q;
  logic        valid_q, wstrb_q, rbuf_full_q, miso_q, underrun_q, frame_done_q;

  logic        sclk_s, ss_s, mosi_s;
  logic        sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic [7:0]  rx_byte, tx_load;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s   = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_prev_q & ~ss_s;
  assign sclk_fall = ~sclk_s & sclk_prev_q & ~ss_s;
  assign ss_rise   = ss_s & ~ss_prev_q;
  assign ss_fall   = armed_q & ss_prev_q & ~ss_s;
  assign rx_byte   = {shift_q[6:0], mosi_s};

  // A falling SS seen right after reset is an artefact of the synchronizer
  // flushing its idle value, so frames are accepted only once SS was truly high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b1;
      settle_q    <= '0;
      armed_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every stage reading the old value of its neighbour.
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], SS};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
      sclk_prev_q <= sclk_s;
      ss_prev_q   <= ss_s;
      if (settle_q != SETTLE) settle_q <= settle_q + 5'd1;
      else if (ss_s)          armed_q  <= 1'b1;
    end
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves tx_load unassigned (no latch).
    tx_load = 8'h00;
    case (op_q)
      OP_READ:   tx_load = rbuf_full_q ? rbuf_q : 8'hFF;
      OP_STATUS: tx_load = status;
      OP_ID: begin
        case (id_idx_q)
          2'd0:    tx_load = ID_VALUE[23:16];
          2'd1:    tx_load = ID_VALUE[15:8];
          2'd2:    tx_load = ID_VALUE[7:0];
          default: tx_load = 8'h00;
        endcase
      end
      default:   tx_load = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      op_q         <= OP_READ;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      tx_q         <= '0;
      tx_cnt_q     <= '0;
      id_idx_q     <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      valid_q      <= 1'b0;
      wstrb_q      <= 1'b0;
      rbuf_q       <= '0;
      rbuf_full_q  <= 1'b0;
      miso_q       <= 1'b0;
      underrun_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;

      // Handshakes complete even after the frame has ended.
      if (valid_q && mem_ready) begin
        valid_q <= 1'b0;
        wstrb_q <= 1'b0;
        if (state_q == TX || state_q == RX) begin
          if (wstrb_q) begin
            addr_q[7:0] <= addr_q[7:0] + 8'd1;
          end else begin
            rbuf_q      <= mem_rdata;
            rbuf_full_q <= 1'b1;
            addr_q      <= addr_q + 24'd1;
          end
        end
      end

      if (ss_rise) begin
        state_q      <= IDLE;
        miso_q       <= 1'b0;
        frame_done_q <= 1'b1;
        bit_cnt_q    <= '0;
        shift_q      <= '0;
      end else if (ss_fall) begin
        state_q     <= CMD;
        bit_cnt_q   <= '0;
        shift_q     <= '0;
        tx_cnt_q    <= '0;
        underrun_q  <= 1'b0;
        rbuf_full_q <= 1'b0;
        miso_q      <= 1'b0;
      end else begin
        case (state_q)
          CMD: if (sclk_rise) begin
            shift_q   <= rx_byte;
            bit_cnt_q <= bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_q <= '0;
              tx_cnt_q  <= '0;
              id_idx_q  <= '0;
              case (rx_byte)
                8'h03:   begin state_q <= ADDR; op_q <= OP_READ;   end
                8'h02:   begin state_q <= ADDR; op_q <= OP_PROG;   end
                8'h9F:   begin state_q <= TX;   op_q <= OP_ID;     end
                8'h05:   begin state_q <= TX;   op_q <= OP_STATUS; end
                default: state_q <= IGNORE;
              endcase
            end
          end
          ADDR: if (sclk_rise) begin
            addr_q    <= {addr_q[22:0], mosi_s};
            bit_cnt_q <= bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd23) begin
              bit_cnt_q <= '0;
              if (op_q == OP_READ) begin
                state_q <= TX;
                valid_q <= 1'b1;
                wstrb_q <= 1'b0;
              end else begin
                state_q <= RX;
              end
            end
          end
          TX: if (sclk_fall) begin
            if (tx_cnt_q == 3'd0) begin
              miso_q   <= tx_load[7];
              tx_q     <= {tx_load[6:0], 1'b0};
              tx_cnt_q <= 3'd7;
              if (op_q == OP_ID && id_idx_q != 2'd3) id_idx_q <= id_idx_q + 2'd1;
              if (op_q == OP_READ) begin
                if (rbuf_full_q) begin
                  rbuf_full_q <= 1'b0;
                  valid_q     <= 1'b1;
                  wstrb_q     <= 1'b0;
                end else begin
                  underrun_q  <= 1'b1;
                end
              end
            end else begin
              miso_q   <= tx_q[7];
              tx_q     <= {tx_q[6:0], 1'b0};
              tx_cnt_q <= tx_cnt_q - 3'd1;
            end
          end
          RX: if (sclk_rise) begin
            shift_q   <= rx_byte;
            bit_cnt_q <= bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_q <= '0;
              if (valid_q) begin
                underrun_q <= 1'b1;
              end else begin
                valid_q <= 1'b1;
                wstrb_q <= 1'b1;
                wdata_q <= rx_byte;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign MISO       = miso_q;
  assign mem_valid  = valid_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_wstrb  = wstrb_q;
  assign underrun   = underrun_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_iob_spi_slave_fl.sv
// Directed bench for iob_spi_slave_fl: drives SPI mode-0 frames and checks
// MISO bytes, memory traffic, underrun and frame_done against fixed values.
module tb_iob_spi_slave_fl;

  localparam int HALF = 80;  // SCLK half period: 8 clk cycles

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        SCLK = 1'b0;
  logic        SS = 1'b1;
  logic        MOSI = 1'b0;
  logic        MISO;
  logic        mem_valid;
  logic [23:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_wstrb;
  logic [7:0]  mem_rdata = 8'h00;
  logic        mem_ready = 1'b0;
  logic [7:0]  status = 8'h00;
  logic        underrun;
  logic        frame_done;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int fd_cnt   = 0;
  logic stall = 1'b0;
  logic miso_seen = 1'b0;
  logic mv_seen = 1'b0;
  logic [23:0] log_addr[$];
  logic        log_wstrb[$];
  logic [7:0]  log_wdata[$];

  iob_spi_slave_fl dut (
    .clk(clk), .rst(rst), .SCLK(SCLK), .SS(SS), .MOSI(MOSI), .MISO(MISO),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .status(status), .underrun(underrun), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Memory model: one-cycle ready, data = addr[7:0] ^ 8'h5A, logs every accepted request.
  always @(negedge clk) begin
    if (mem_valid && !mem_ready && !stall) begin
      mem_ready = 1'b1;
      mem_rdata = mem_addr[7:0] ^ 8'h5A;
      log_addr.push_back(mem_addr);
      log_wstrb.push_back(mem_wstrb);
      log_wdata.push_back(mem_wdata);
    end else begin
      mem_ready = 1'b0;
    end
    if (MISO)       miso_seen = 1'b1;
    if (mem_valid)  mv_seen = 1'b1;
    if (frame_done) fd_cnt++;
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      MOSI = tx[i];
      #(HALF);
      rx[i] = MISO;
      SCLK = 1'b1;
      #(HALF);
      SCLK = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] tx);
    logic [7:0] dummy;
    spi_xfer(tx, 8, dummy);
  endtask

  task automatic frame_start;
    @(negedge clk);
    SS = 1'b0;
    #(HALF);
  endtask

  task automatic frame_end;
    #(HALF);
    SS = 1'b1;
    MOSI = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk_cnt++; if (MISO !== 1'b0)        $display("FAIL reset_miso: got %b exp 0", MISO); else pass_cnt++;
    chk_cnt++; if (mem_valid !== 1'b0)   $display("FAIL reset_valid: got %b exp 0", mem_valid); else pass_cnt++;
    chk_cnt++; if (mem_wstrb !== 1'b0)   $display("FAIL reset_wstrb: got %b exp 0", mem_wstrb); else pass_cnt++;
    chk_cnt++; if (mem_addr !== 24'h0)   $display("FAIL reset_addr: got %h exp 000000", mem_addr); else pass_cnt++;
    chk_cnt++; if (mem_wdata !== 8'h0)   $display("FAIL reset_wdata: got %h exp 00", mem_wdata); else pass_cnt++;
    chk_cnt++; if (underrun !== 1'b0)    $display("FAIL reset_underrun: got %b exp 0", underrun); else pass_cnt++;
    chk_cnt++; if (frame_done !== 1'b0)  $display("FAIL reset_frame_done: got %b exp 0", frame_done); else pass_cnt++;
    rst = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_jedec_id;
    logic [7:0] exp_id [4] = '{8'hEF, 8'h40, 8'h18, 8'h00};
    logic [7:0] rx;
    int fd0 = fd_cnt;
    frame_start;
    send(8'h9F);
    for (int k = 0; k < 4; k++) begin
      spi_xfer(8'h00, 8, rx);
      chk_cnt++; if (rx !== exp_id[k]) $display("FAIL id_byte%0d: got %h exp %h", k, rx, exp_id[k]); else pass_cnt++;
    end
    frame_end;
    chk_cnt++; if (fd_cnt !== fd0 + 1) $display("FAIL id_frame_done: got %0d pulses exp 1", fd_cnt - fd0); else pass_cnt++;
    chk_cnt++; if (MISO !== 1'b0) $display("FAIL id_miso_idle: got %b exp 0", MISO); else pass_cnt++;
  endtask

  task automatic test_read_wrap;
    logic [7:0]  exp_d [3] = '{8'hA4, 8'hA5, 8'h5A};
    logic [23:0] exp_a [3] = '{24'hFFFFFE, 24'hFFFFFF, 24'h000000};
    logic [7:0]  rx;
    log_addr.delete(); log_wstrb.delete(); log_wdata.delete();
    frame_start;
    send(8'h03); send(8'hFF); send(8'hFF); send(8'hFE);
    for (int k = 0; k < 3; k++) begin
      spi_xfer(8'h00, 8, rx);
      chk_cnt++; if (rx !== exp_d[k]) $display("FAIL read_byte%0d: got %h exp %h", k, rx, exp_d[k]); else pass_cnt++;
    end
    frame_end;
    chk_cnt++; if (log_addr.size() < 3) $display("FAIL read_req_count: got %0d exp >=3", log_addr.size()); else pass_cnt++;
    for (int k = 0; k < 3 && k < log_addr.size(); k++) begin
      chk_cnt++; if (log_addr[k] !== exp_a[k] || log_wstrb[k] !== 1'b0)
        $display("FAIL read_addr%0d: got %h wstrb %b exp %h wstrb 0", k, log_addr[k], log_wstrb[k], exp_a[k]); else pass_cnt++;
    end
    chk_cnt++; if (underrun !== 1'b0) $display("FAIL read_underrun: got %b exp 0", underrun); else pass_cnt++;
  endtask

  task automatic test_program;
    logic [23:0] exp_a [3] = '{24'h0012FE, 24'h0012FF, 24'h001200};
    logic [7:0]  exp_d [3] = '{8'hA1, 8'hB2, 8'hC3};
    log_addr.delete(); log_wstrb.delete(); log_wdata.delete();
    frame_start;
    send(8'h02); send(8'h00); send(8'h12); send(8'hFE);
    for (int k = 0; k < 3; k++) send(exp_d[k]);
    frame_end;
    chk_cnt++; if (log_addr.size() != 3) $display("FAIL prog_write_count: got %0d exp 3", log_addr.size()); else pass_cnt++;
    for (int k = 0; k < 3 && k < log_addr.size(); k++) begin
      chk_cnt++; if (log_addr[k] !== exp_a[k] || log_wdata[k] !== exp_d[k] || log_wstrb[k] !== 1'b1)
        $display("FAIL prog_write%0d: got (%h,%h,w%b) exp (%h,%h,w1)", k, log_addr[k], log_wdata[k], log_wstrb[k], exp_a[k], exp_d[k]); else pass_cnt++;
    end
    chk_cnt++; if (underrun !== 1'b0) $display("FAIL prog_underrun: got %b exp 0", underrun); else pass_cnt++;
  endtask

  task automatic test_underrun;
    logic [7:0] rx1, rx2;
    stall = 1'b1;
    frame_start;
    send(8'h03); send(8'h00); send(8'h00); send(8'h10);
    fork
      begin repeat (20) @(posedge clk); stall = 1'b0; end
      spi_xfer(8'h00, 8, rx1);
    join
    spi_xfer(8'h00, 8, rx2);
    chk_cnt++; if (rx1 !== 8'hFF) $display("FAIL underrun_byte0: got %h exp ff", rx1); else pass_cnt++;
    chk_cnt++; if (rx2 !== 8'h4A) $display("FAIL underrun_byte1: got %h exp 4a", rx2); else pass_cnt++;
    chk_cnt++; if (underrun !== 1'b1) $display("FAIL underrun_set: got %b exp 1", underrun); else pass_cnt++;
    frame_end;
    chk_cnt++; if (underrun !== 1'b1) $display("FAIL underrun_sticky: got %b exp 1", underrun); else pass_cnt++;
  endtask

  task automatic test_status;
    logic [7:0] rx1, rx2;
    status = 8'h3C;
    frame_start;
    repeat (4) @(negedge clk);
    chk_cnt++; if (underrun !== 1'b0) $display("FAIL underrun_clear: got %b exp 0", underrun); else pass_cnt++;
    send(8'h05);
    fork
      spi_xfer(8'h00, 8, rx1);
      begin #(HALF * 4); status = 8'hC5; end
    join
    spi_xfer(8'h00, 8, rx2);
    frame_end;
    chk_cnt++; if (rx1 !== 8'h3C) $display("FAIL status_byte0: got %h exp 3c", rx1); else pass_cnt++;
    chk_cnt++; if (rx2 !== 8'hC5) $display("FAIL status_byte1: got %h exp c5", rx2); else pass_cnt++;
  endtask

  task automatic test_partial_program;
    logic [7:0] rx;
    int fd0 = fd_cnt;
    log_addr.delete(); log_wstrb.delete(); log_wdata.delete();
    frame_start;
    send(8'h02); send(8'h00); send(8'h00); send(8'h40);
    spi_xfer(8'hA5, 5, rx);
    frame_end;
    chk_cnt++; if (log_addr.size() != 0) $display("FAIL partial_no_write: got %0d writes exp 0", log_addr.size()); else pass_cnt++;
    chk_cnt++; if (fd_cnt !== fd0 + 1) $display("FAIL partial_frame_done: got %0d pulses exp 1", fd_cnt - fd0); else pass_cnt++;
    frame_start;
    send(8'h9F);
    spi_xfer(8'h00, 8, rx);
    frame_end;
    chk_cnt++; if (rx !== 8'hEF) $display("FAIL partial_then_idle: got %h exp ef", rx); else pass_cnt++;
  endtask

  task automatic test_ignore;
    logic [7:0] rx1, rx2;
    int fd0 = fd_cnt;
    frame_start;
    miso_seen = 1'b0;
    mv_seen = 1'b0;
    send(8'h55);
    spi_xfer(8'hFF, 8, rx1);
    spi_xfer(8'hFF, 8, rx2);
    frame_end;
    chk_cnt++; if ({rx1, rx2} !== 16'h0000) $display("FAIL ignore_miso_bytes: got %h%h exp 0000", rx1, rx2); else pass_cnt++;
    chk_cnt++; if (miso_seen !== 1'b0) $display("FAIL ignore_miso_low: got %b exp 0", miso_seen); else pass_cnt++;
    chk_cnt++; if (mv_seen !== 1'b0) $display("FAIL ignore_no_valid: got %b exp 0", mv_seen); else pass_cnt++;
    chk_cnt++; if (fd_cnt !== fd0 + 1) $display("FAIL ignore_frame_done: got %0d pulses exp 1", fd_cnt - fd0); else pass_cnt++;
  endtask

  task automatic test_reset_mid_read;
    logic [7:0] rx;
    log_addr.delete(); log_wstrb.delete(); log_wdata.delete();
    frame_start;
    send(8'h03); send(8'h12);
    spi_xfer(8'h34, 4, rx);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_cnt++; if ({MISO, mem_valid, mem_wstrb, underrun, frame_done} !== 5'b0)
      $display("FAIL midrst_flags: got %b exp 00000", {MISO, mem_valid, mem_wstrb, underrun, frame_done}); else pass_cnt++;
    chk_cnt++; if (mem_addr !== 24'h0) $display("FAIL midrst_addr: got %h exp 000000", mem_addr); else pass_cnt++;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    miso_seen = 1'b0;
    mv_seen = 1'b0;
    send(8'h9F);
    send(8'h00);
    chk_cnt++; if (miso_seen !== 1'b0 || mv_seen !== 1'b0)
      $display("FAIL midrst_wait_fresh_ss: got miso %b valid %b exp 0 0", miso_seen, mv_seen); else pass_cnt++;
    frame_end;
    chk_cnt++; if (log_addr.size() != 0) $display("FAIL midrst_no_mem: got %0d requests exp 0", log_addr.size()); else pass_cnt++;
    status = 8'h81;
    frame_start;
    send(8'h05);
    spi_xfer(8'h00, 8, rx);
    frame_end;
    chk_cnt++; if (rx !== 8'h81) $display("FAIL midrst_status: got %h exp 81", rx); else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_jedec_id;
    test_read_wrap;
    test_program;
    test_underrun;
    test_status;
    test_partial_program;
    test_ignore;
    test_reset_mid_read;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/iob_spi_slave_fl.md
IOB_SPI_SLAVE_FL -- requirements
Module: iob_spi_slave_fl

Interface
REQ-001 SHALL have parameter ID_VALUE, default 24'hEF4018, JEDEC ID returned by command 0x9F, MSB first.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, number of flip-flop stages in each SCLK/SS/MOSI input synchronizer.
REQ-003 SHALL use one clock and a synchronous active-high reset: clk  in  1  system clock; rst  in  1  synchronous active-high reset.
REQ-004 SCLK  in  1  SPI clock from master, asynchronous to clk.
REQ-005 SS  in  1  slave select, active low.
REQ-006 MOSI  in  1  serial data from master.
REQ-007 MISO  out  1  serial data to master.
REQ-008 mem_valid  out  1  memory request.
REQ-009 mem_addr  out  24  byte address.
REQ-010 mem_wdata  out  8  write byte.
REQ-011 mem_wstrb  out  1  1 = write, 0 = read.
REQ-012 mem_rdata  in  8  read byte.
REQ-013 mem_ready  in  1  request accepted or completed.
REQ-014 status  in  8  byte returned by command 0x05.
REQ-015 underrun  out  1  sticky read-underrun flag.
REQ-016 frame_done  out  1  one-cycle pulse at frame end.

Function
REQ-017 SHALL support SPI mode 0, single-line, MSB first: sample MOSI on synchronized SCLK rising edge; update MISO on falling edge; clk SHALL be at least 8x SCLK.
REQ-018 SCLK, SS and MOSI SHALL pass through SYNC_STAGES flip-flops; edges SHALL be detected from registered copies only.
REQ-019 FSM states SHALL be IDLE, CMD, ADDR, TX, RX and IGNORE.
REQ-020 IDLE->CMD on SS falling edge; CMD SHALL shift 8 bits, then decode.
REQ-021 Command 0x03 (READ) SHALL go CMD->ADDR (24 bits) ->TX, streaming bytes from memory.
REQ-022 Command 0x02 (PROGRAM) SHALL go CMD->ADDR->RX, writing each received byte to memory.
REQ-023 Command 0x9F SHALL go to TX and send the 3 ID_VALUE bytes, then 0x00.
REQ-024 Command 0x05 SHALL go to TX and send status repeatedly, re-sampling it at each byte boundary.
REQ-025 Any other opcode SHALL go to IGNORE, holding MISO = 0 until SS rises.
REQ-026 READ prefetch: mem_valid=1 with mem_wstrb=0 SHALL be issued the cycle after the last address bit is sampled, and again after each byte is loaded into the TX shifter.
REQ-027 mem_valid SHALL hold until mem_ready; mem_rdata SHALL be captured in the mem_ready cycle.
REQ-028 If no byte has been captured when a TX byte must load on a falling edge, the block SHALL send 0xFF and set underrun.
REQ-029 The READ address SHALL increment by 1 per byte and wrap from 24'hFFFFFF to 0.
REQ-030 PROGRAM: after the 8th bit of each data byte, the block SHALL issue mem_valid=1, mem_wstrb=1, mem_wdata = byte.
REQ-031 The PROGRAM address SHALL increment only within a page, addr[7:0] wrapping 0xFF->0x00 while addr[23:8] is unchanged.
REQ-032 If a PROGRAM write is still pending when the next byte completes, the new byte SHALL be dropped and underrun set.
REQ-033 On SS rising edge in any state: discard any partial byte with no write; let an outstanding memory request finish its handshake; pulse frame_done; go to IDLE.
REQ-034 MISO SHALL be 0 whenever SS is high or the FSM is not in TX.
REQ-035 underrun SHALL clear on SS falling edge.
REQ-036 SCLK edges while SS is high SHALL be ignored.

Reset
REQ-037 While rst=1 the block SHALL force: FSM=IDLE, MISO=0, mem_valid=0, mem_wstrb=0, mem_addr=0, mem_wdata=0, underrun=0, frame_done=0, shifters and bit counters=0, synchronizers to idle (SS=1, SCLK=0).
REQ-038 Reset asserted mid-frame SHALL abort the frame with no memory write; the block SHALL wait for a fresh SS falling edge afterwards.

Verification
REQ-039 Send 0x9F -> MISO returns 0xEF, 0x40, 0x18, then 0x00; frame_done pulses once after SS rises.
REQ-040 READ 0x03 at address 0xFFFFFE, 3 bytes, memory model with 1-cycle ready -> mem_addr sequence 0xFFFFFE, 0xFFFFFF, 0x000000; MISO returns the model's data; underrun=0.
REQ-041 PROGRAM 0x02 at 0x0012FE with data 0xA1, 0xB2, 0xC3 -> writes (0x0012FE, A1), (0x0012FF, B2), (0x001200, C3).
REQ-042 READ with mem_ready held low for 20 cycles -> first byte on MISO = 0xFF; underrun=1 until the next SS falling edge.
REQ-043 SS rises after 5 bits of a PROGRAM data byte -> no write issued, FSM returns to IDLE, frame_done pulses.
REQ-044 Opcode 0x55 followed by 16 clocks -> MISO stays 0 and no mem_valid; rst pulsed mid-READ -> all outputs at reset values and the next 0x05 frame returns status.
